// File: rtl/aes_msg_feeder_pkg.sv
// Shared definitions for the AES byte-stream front end: byte width, default
// message capacity and the feeder state encoding.
package aes_stream_pkg;

    localparam int AES_BYTE_W     = 8;
    localparam int FEEDER_MAX_LEN = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        START  = 2'd2,
        STREAM = 2'd3
    } feeder_state_t;

    // A header is usable only if it carries at least one byte and fits the buffer.
    function automatic logic hdr_len_ok(input int unsigned len, input int unsigned max_len);
        return (len != 32'd0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/aes_msg_feeder_if.sv
// Header and payload handshakes plus the cipher-facing stream, bundled so the
// producer (master) and the feeder (slave) share one port list.
interface aes_msg_feeder_if
    import aes_stream_pkg::*;
#(
    parameter int LEN_W = $clog2(FEEDER_MAX_LEN + 1)
);

    logic                  hdr_valid;
    logic                  hdr_ready;
    logic [AES_BYTE_W-1:0] hdr_key;
    logic [LEN_W-1:0]      hdr_len;

    logic                  s_valid;
    logic                  s_ready;
    logic [AES_BYTE_W-1:0] s_data;

    logic                  new_message;
    logic [AES_BYTE_W-1:0] key;
    logic                  valid_in;
    logic [AES_BYTE_W-1:0] data_in;
    logic                  busy;
    logic                  err;

    modport master (
        output hdr_valid, hdr_key, hdr_len, s_valid, s_data,
        input  hdr_ready, s_ready, new_message, key, valid_in, data_in, busy, err
    );

    modport slave (
        input  hdr_valid, hdr_key, hdr_len, s_valid, s_data,
        output hdr_ready, s_ready, new_message, key, valid_in, data_in, busy, err
    );

endinterface

// File: rtl/aes_msg_feeder_msg_byte_buffer.sv
// Message payload store: synchronous write, combinational read. Contents are
// deliberately not reset; every byte is rewritten before it is streamed.
module msg_byte_buffer
    import aes_stream_pkg::*;
#(
    parameter int DEPTH  = FEEDER_MAX_LEN,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [AES_BYTE_W-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [AES_BYTE_W-1:0] rdata
);

    logic [AES_BYTE_W-1:0] mem_q [DEPTH];

    // Payload write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/aes_msg_feeder.sv
// Buffers a whole message, then emits a one-cycle start pulse followed by a
// gap-free byte burst so the cipher keystream never falls out of step.
module aes_msg_feeder
    import aes_stream_pkg::*;
#(
    parameter int MAX_LEN = FEEDER_MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic            clk,
    input  logic            reset,
    aes_msg_feeder_if.slave bus
);

    localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    feeder_state_t         state_q, state_d;
    logic [LEN_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [LEN_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [AES_BYTE_W-1:0] lkey_q, lkey_d;

    logic                  hdr_ready_q, hdr_ready_d;
    logic                  s_ready_q, s_ready_d;
    logic                  new_msg_q, new_msg_d;
    logic [AES_BYTE_W-1:0] key_q, key_d;
    logic                  valid_q, valid_d;
    logic [AES_BYTE_W-1:0] data_q, data_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;

    logic                  hdr_fire_s;
    logic                  s_fire_s;
    logic                  buf_we_s;
    logic [AES_BYTE_W-1:0] buf_rdata_s;

    // Ready outputs are registered, so a handshake is qualified by what the
    // producer actually saw this cycle.
    assign hdr_fire_s = bus.hdr_valid & hdr_ready_q;
    assign s_fire_s   = bus.s_valid & s_ready_q;

    msg_byte_buffer #(
        .DEPTH  (MAX_LEN),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we_s),
        .waddr (wr_ptr_q[ADDR_W-1:0]),
        .wdata (bus.s_data),
        .raddr (rd_ptr_q[ADDR_W-1:0]),
        .rdata (buf_rdata_s)
    );

    // Next-state, pointer and output-register decode
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        len_d     = len_q;
        lkey_d    = lkey_q;
        buf_we_s  = 1'b0;
        new_msg_d = 1'b0;
        key_d     = key_q;
        valid_d   = 1'b0;
        data_d    = {AES_BYTE_W{1'b0}};
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (hdr_fire_s) begin
                    lkey_d   = bus.hdr_key;
                    len_d    = bus.hdr_len;
                    wr_ptr_d = {LEN_W{1'b0}};
                    rd_ptr_d = {LEN_W{1'b0}};
                    if (hdr_len_ok(32'(bus.hdr_len), 32'(MAX_LEN))) begin
                        state_d = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (s_fire_s) begin
                    buf_we_s = 1'b1;
                    wr_ptr_d = wr_ptr_q + LEN_W'(1);
                    if (wr_ptr_q == (len_q - LEN_W'(1))) begin
                        state_d   = START;
                        new_msg_d = 1'b1;
                        key_d     = lkey_q;
                    end else begin
                        state_d = LOAD;
                    end
                end else begin
                    state_d = LOAD;
                end
            end
            START: begin
                // The pulse cycle preloads byte 0 so the burst starts right after it.
                state_d  = STREAM;
                valid_d  = 1'b1;
                data_d   = buf_rdata_s;
                rd_ptr_d = rd_ptr_q + LEN_W'(1);
            end
            STREAM: begin
                if (rd_ptr_q == len_q) begin
                    state_d = IDLE;
                end else begin
                    valid_d  = 1'b1;
                    data_d   = buf_rdata_s;
                    rd_ptr_d = rd_ptr_q + LEN_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        hdr_ready_d = (state_d == IDLE);
        s_ready_d   = (state_d == LOAD);
        busy_d      = (state_d != IDLE);
    end

    // State, pointers and every externally visible output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= {LEN_W{1'b0}};
            rd_ptr_q    <= {LEN_W{1'b0}};
            len_q       <= {LEN_W{1'b0}};
            lkey_q      <= {AES_BYTE_W{1'b0}};
            hdr_ready_q <= 1'b0;
            s_ready_q   <= 1'b0;
            new_msg_q   <= 1'b0;
            key_q       <= {AES_BYTE_W{1'b0}};
            valid_q     <= 1'b0;
            data_q      <= {AES_BYTE_W{1'b0}};
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            len_q       <= len_d;
            lkey_q      <= lkey_d;
            hdr_ready_q <= hdr_ready_d;
            s_ready_q   <= s_ready_d;
            new_msg_q   <= new_msg_d;
            key_q       <= key_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign bus.hdr_ready   = hdr_ready_q;
    assign bus.s_ready     = s_ready_q;
    assign bus.new_message = new_msg_q;
    assign bus.key         = key_q;
    assign bus.valid_in    = valid_q;
    assign bus.data_in     = data_q;
    assign bus.busy        = busy_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_aes_msg_feeder.sv
// Directed bench for aes_msg_feeder: cycle-exact framing, contiguity, rejects,
// mid-stream reset and a full-buffer back-to-back pair.
module tb_aes_msg_feeder;
    import aes_stream_pkg::*;

    localparam int MAX_LEN = 64;
    localparam int LEN_W   = 7;

    typedef logic [7:0] byte_t;
    typedef byte_t      byte_q_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    aes_msg_feeder_if #(.LEN_W(LEN_W)) bus();

    aes_msg_feeder #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stream monitor, sampled mid-cycle
    int      nm_cnt = 0, nm_cyc = 0, v_cnt = 0, v_first = 0, v_last = 0;
    int      err_cnt = 0, err_cyc = 0, hr_rise = 0, dz_bad = 0;
    byte_t   nm_key = 8'h00;
    byte_t   v_data[$];
    logic    hr_prev = 1'b0;
    logic    mon_clr = 1'b0;

    always @(negedge clk) begin
        if (mon_clr) begin
            nm_cnt  <= 0;
            v_cnt   <= 0;
            err_cnt <= 0;
            v_data.delete();
        end else begin
            if (bus.new_message) begin
                nm_cnt <= nm_cnt + 1;
                nm_cyc <= cyc;
                nm_key <= bus.key;
            end
            if (bus.valid_in) begin
                if (v_cnt == 0) v_first <= cyc;
                v_last <= cyc;
                v_cnt  <= v_cnt + 1;
                v_data.push_back(bus.data_in);
            end
            if (bus.err) begin
                err_cnt <= err_cnt + 1;
                err_cyc <= cyc;
            end
        end
        if (!bus.valid_in && bus.data_in != 8'h00) dz_bad <= dz_bad + 1;
        if (bus.hdr_ready && !hr_prev) hr_rise <= cyc;
        hr_prev <= bus.hdr_ready;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        step();
        mon_clr = 1'b0;
    endtask

    task automatic send_hdr(input byte_t k, input int len, output int hs);
        hs = -1;
        bus.hdr_valid = 1'b1;
        bus.hdr_key   = k;
        bus.hdr_len   = LEN_W'(len);
        for (int i = 0; i < 400; i++) begin
            if (bus.hdr_ready) begin
                hs = cyc;
                break;
            end
            step();
        end
        if (hs < 0) check_eq("hdr_timeout", 32'(bus.hdr_ready), 32'd1);
        else step();
        bus.hdr_valid = 1'b0;
    endtask

    task automatic send_bytes(input byte_q_t d, input bit gaps, output int last);
        last = -1;
        foreach (d[i]) begin
            bit ok = 1'b0;
            if (gaps) repeat ($urandom_range(0, 2)) step();
            bus.s_valid = 1'b1;
            bus.s_data  = d[i];
            for (int j = 0; j < 100; j++) begin
                if (bus.s_ready) begin
                    last = cyc;
                    ok   = 1'b1;
                    break;
                end
                step();
            end
            if (!ok) check_eq("s_timeout", 32'(bus.s_ready), 32'd1);
            step();
            bus.s_valid = 1'b0;
        end
    endtask

    task automatic wait_ready();
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (bus.hdr_ready) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) check_eq("idle_timeout", 32'(bus.hdr_ready), 32'd1);
        step();
    endtask

    task automatic check_msg(input string tag, input byte_t k, input byte_q_t exp, input int u);
        int bad = 0;
        int n   = exp.size();
        check_eq({tag, "_nm_cnt"},  32'(nm_cnt),  32'd1);
        check_eq({tag, "_nm_cyc"},  32'(nm_cyc),  32'(u + 1));
        check_eq({tag, "_nm_key"},  32'(nm_key),  32'(k));
        check_eq({tag, "_key_hold"},32'(bus.key), 32'(k));
        check_eq({tag, "_v_cnt"},   32'(v_cnt),   32'(n));
        check_eq({tag, "_v_first"}, 32'(v_first), 32'(u + 2));
        check_eq({tag, "_v_last"},  32'(v_last),  32'(u + 1 + n));
        for (int i = 0; i < n; i++) begin
            if (i >= v_data.size() || v_data[i] !== exp[i]) bad++;
        end
        check_eq({tag, "_data_bad"}, 32'(bad), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int      hs, hs2, u;
        byte_q_t d;

        bus.hdr_valid = 1'b0;
        bus.hdr_key   = 8'h00;
        bus.hdr_len   = '0;
        bus.s_valid   = 1'b0;
        bus.s_data    = 8'h00;

        // Reset state
        rst = 1'b1;
        step();
        step();
        check_eq("rst_hdr_ready", 32'(bus.hdr_ready),   32'd0);
        check_eq("rst_s_ready",   32'(bus.s_ready),     32'd0);
        check_eq("rst_busy",      32'(bus.busy),        32'd0);
        check_eq("rst_new_msg",   32'(bus.new_message), 32'd0);
        check_eq("rst_valid_in",  32'(bus.valid_in),    32'd0);
        check_eq("rst_key",       32'(bus.key),         32'd0);
        check_eq("rst_data_in",   32'(bus.data_in),     32'd0);
        check_eq("rst_err",       32'(bus.err),         32'd0);
        rst = 1'b0;
        step();
        check_eq("post_rst_hdr_ready", 32'(bus.hdr_ready), 32'd1);

        // Single message, key 00 len 3
        clear_mon();
        send_hdr(8'h00, 3, hs);
        check_eq("t1_s_ready", 32'(bus.s_ready), 32'd1);
        check_eq("t1_busy",    32'(bus.busy),    32'd1);
        d = '{8'h00, 8'h00, 8'h00};
        send_bytes(d, 1'b0, u);
        wait_ready();
        check_msg("t1", 8'h00, d, u);
        check_eq("t1_hdr_ready_rise", 32'(hr_rise), 32'(u + 2 + 3));

        // Key FF, len 2
        clear_mon();
        send_hdr(8'hFF, 2, hs);
        d = '{8'h00, 8'h00};
        send_bytes(d, 1'b0, u);
        wait_ready();
        check_msg("t2", 8'hFF, d, u);

        // Stalled LOAD, len 5
        clear_mon();
        send_hdr(8'h3C, 5, hs);
        d = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
        send_bytes(d, 1'b1, u);
        wait_ready();
        check_msg("t3", 8'h3C, d, u);
        check_eq("t3_hdr_ready_rise", 32'(hr_rise), 32'(u + 2 + 5));

        // Rejected headers: len 0, then MAX_LEN+1
        clear_mon();
        send_hdr(8'h99, 0, hs);
        step();
        check_eq("t4a_err_cnt",   32'(err_cnt),       32'd1);
        check_eq("t4a_err_cyc",   32'(err_cyc),       32'(hs + 1));
        check_eq("t4a_hdr_ready", 32'(bus.hdr_ready), 32'd1);
        check_eq("t4a_busy",      32'(bus.busy),      32'd0);
        send_hdr(8'h98, MAX_LEN + 1, hs);
        step();
        check_eq("t4b_err_cnt",   32'(err_cnt),       32'd2);
        check_eq("t4b_err_cyc",   32'(err_cyc),       32'(hs + 1));
        check_eq("t4b_hdr_ready", 32'(bus.hdr_ready), 32'd1);
        check_eq("t4_nm_cnt",     32'(nm_cnt),        32'd0);
        check_eq("t4_v_cnt",      32'(v_cnt),         32'd0);
        check_eq("t4_key_held",   32'(bus.key),       32'h3C);

        // Reset during STREAM, then a len 1 message
        clear_mon();
        send_hdr(8'h5A, 8, hs);
        d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
        send_bytes(d, 1'b0, u);
        step();
        step();
        check_eq("t5_streaming", 32'(bus.valid_in), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("t5_rst_valid_in",  32'(bus.valid_in),  32'd0);
        check_eq("t5_rst_busy",      32'(bus.busy),      32'd0);
        check_eq("t5_rst_data_in",   32'(bus.data_in),   32'd0);
        check_eq("t5_rst_hdr_ready", 32'(bus.hdr_ready), 32'd0);
        step();
        rst = 1'b0;
        step();
        check_eq("t5_hdr_ready_back", 32'(bus.hdr_ready), 32'd1);
        clear_mon();
        send_hdr(8'h11, 1, hs);
        d = '{8'hC3};
        send_bytes(d, 1'b0, u);
        wait_ready();
        check_msg("t5", 8'h11, d, u);

        // Full buffer followed immediately by another header
        clear_mon();
        send_hdr(8'h77, MAX_LEN, hs);
        d = {};
        for (int i = 0; i < MAX_LEN; i++) d.push_back(byte_t'(i * 7 + 3));
        send_bytes(d, 1'b0, u);
        send_hdr(8'h88, 2, hs2);
        check_eq("t6_hdr2_cyc",   32'(hs2),     32'(u + 2 + MAX_LEN));
        check_eq("t6_hdr2_after", 32'(hs2),     32'(v_last + 1));
        check_msg("t6a", 8'h77, d, u);
        clear_mon();
        d = '{8'h5E, 8'hE5};
        send_bytes(d, 1'b0, u);
        wait_ready();
        check_msg("t6b", 8'h88, d, u);

        check_eq("data_zero_when_idle", 32'(dz_bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
